vlc_pack_ctrl: RTL and testbench

Sequences the Huffman VLC stream into the output bitstream. It consumes 22-bit VLC words in the {last, length[4:0], code[15:0]} format and packs the valid code bits MSB-first into 32-bit output words over a valid/ready handshake. On the last code it flushes the partial word, zero-padded, and reports the number of meaningful bytes. It sits between the Huffman table lookup and the compressed-output FIFO.

---
 rtl/vlc_pack_ctrl_pkg.sv | 22 ++
 rtl/vlc_align_merge.sv | 28 ++
 rtl/vlc_pack_ctrl.sv | 145 ++++++++++++++
 tb/tb_vlc_pack_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vlc_pack_ctrl_pkg.sv
// Shared Huffman VLC constants: field widths, VLC word layout and packer states.
package vlc_pack_ctrl_pkg;

   localparam int unsigned CODE_W = 16;
   localparam int unsigned LEN_W  = 5;
   localparam int unsigned OUT_W  = 32;
   localparam int unsigned BUF_W  = 2 * OUT_W;
   localparam int unsigned FILL_W = 7;
   localparam int unsigned BYTE_W = 3;
   localparam int unsigned VLC_W  = 1 + LEN_W + CODE_W;

   // VLC word layout {last, length, code}; shared with the code-length extraction stage
   localparam int unsigned LAST_BIT = 21;
   localparam int unsigned LEN_HI   = 20;
   localparam int unsigned LEN_LO   = 16;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } pack_state_e;

endpackage

// File: rtl/vlc_align_merge.sv
// Places a length-masked code just below the current fill point of the MSB-aligned
// bit buffer and ORs it in.
//   buf_in   : buffer contents (bits below fill are zero)
//   fill     : number of valid bits in buf_in (0..64)
//   code     : raw code field; only code[len-1:0] is used
//   len      : code length, already clamped to 0..CODE_W
//   buf_out  : buf_in with the code merged at [BUF_W-1-fill -: len]
module vlc_align_merge
   import vlc_pack_ctrl_pkg::*;
(
   input  logic [BUF_W-1:0]  buf_in,
   input  logic [FILL_W-1:0] fill,
   input  logic [CODE_W-1:0] code,
   input  logic [LEN_W-1:0]  len,
   output logic [BUF_W-1:0]  buf_out
);

   logic [BUF_W-1:0] code_ext;
   logic [7:0]       shamt;

   // Shift amount uses 8 bits so 64-fill-len cannot wrap for any accepted code
   always_comb begin
      code_ext = BUF_W'(code) & ((BUF_W'(1) << len) - BUF_W'(1));
      shamt    = 8'(BUF_W) - 8'(fill) - 8'(len);
      buf_out  = buf_in | (code_ext << shamt);
   end

endmodule

// File: rtl/vlc_pack_ctrl.sv
// Packs {last, length, code} VLC words MSB-first into 32-bit output words and
// flushes the zero-padded partial word at the end of a stream.
//   clk, rstN      : clock, asynchronous active-low reset
//   clr            : synchronous clear of buffer, state and len_err
//   vlc_code/valid : input VLC word and handshake; vlc_ready from registers only
//   out_word/valid : packed output word and handshake with out_ready
//   out_last       : final word of a stream
//   out_bytes      : meaningful bytes in out_word (0..4)
//   len_err        : sticky, a code length above CODE_W was seen
//   busy           : packer holds state, bits, or an undelivered word
module vlc_pack_ctrl
   import vlc_pack_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rstN,
   input  logic             clr,
   input  logic [VLC_W-1:0] vlc_code,
   input  logic             vlc_valid,
   output logic             vlc_ready,
   output logic [OUT_W-1:0] out_word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic [BYTE_W-1:0] out_bytes,
   output logic             len_err,
   output logic             busy
);

   pack_state_e       state_q, state_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [BUF_W-1:0]  buf_q, buf_d;
   logic [OUT_W-1:0]  out_word_q, out_word_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic [BYTE_W-1:0] out_bytes_q, out_bytes_d;
   logic              len_err_q, len_err_d;

   logic [LEN_W-1:0]  code_len_raw, code_len;
   logic              len_ovf, accept, emit, last_emit;
   logic [FILL_W-1:0] drain, fill_mid;
   logic [BUF_W-1:0]  buf_mid, buf_merged;

   assign vlc_ready = (state_q == RUN) && (fill_q <= FILL_W'(BUF_W - CODE_W));
   assign out_word  = out_word_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_bytes = out_bytes_q;
   assign len_err   = len_err_q;
   assign busy      = (state_q != RUN) || (fill_q != '0) || out_valid_q;

   // Buffer after this cycle's drain; an accepted code lands just below it
   always_comb begin
      code_len_raw = vlc_code[LEN_HI:LEN_LO];
      len_ovf      = code_len_raw > LEN_W'(CODE_W);
      code_len     = len_ovf ? LEN_W'(CODE_W) : code_len_raw;
      accept       = vlc_valid && vlc_ready;
      emit         = (!out_valid_q || out_ready) &&
                     ((state_q == FLUSH) || (fill_q >= FILL_W'(OUT_W)));
      last_emit    = emit && (state_q == FLUSH) && (fill_q <= FILL_W'(OUT_W));
      drain        = !emit ? '0 :
                     (fill_q >= FILL_W'(OUT_W)) ? FILL_W'(OUT_W) : fill_q;
      fill_mid     = fill_q - drain;
      buf_mid      = emit ? {buf_q[OUT_W-1:0], OUT_W'(0)} : buf_q;
   end

   vlc_align_merge u_align_merge (
      .buf_in  (buf_mid),
      .fill    (fill_mid),
      .code    (vlc_code[CODE_W-1:0]),
      .len     (code_len),
      .buf_out (buf_merged)
   );

   // Next-state, buffer and output register update
   always_comb begin
      state_d     = state_q;
      fill_d      = fill_mid;
      buf_d       = buf_mid;
      out_word_d  = out_word_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_bytes_d = out_bytes_q;
      len_err_d   = len_err_q;

      if (emit) begin
         out_word_d  = buf_q[BUF_W-1:OUT_W];
         out_valid_d = 1'b1;
         out_last_d  = last_emit;
         if (state_q == FLUSH && fill_q < FILL_W'(OUT_W)) begin
            out_bytes_d = BYTE_W'((fill_q + FILL_W'(7)) >> 3);
         end else begin
            out_bytes_d = BYTE_W'(4);
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         buf_d  = buf_merged;
         fill_d = fill_mid + FILL_W'(code_len);
         if (len_ovf) len_err_d = 1'b1;
         if (vlc_code[LAST_BIT]) state_d = FLUSH;
      end

      if (last_emit) begin
         state_d = RUN;
         fill_d  = '0;
         buf_d   = '0;
      end

      if (clr) begin
         state_d     = RUN;
         fill_d      = '0;
         buf_d       = '0;
         out_word_d  = '0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
         out_bytes_d = '0;
         len_err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= RUN;
         fill_q      <= '0;
         buf_q       <= '0;
         out_word_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_bytes_q <= '0;
         len_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         buf_q       <= buf_d;
         out_word_q  <= out_word_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_bytes_q <= out_bytes_d;
         len_err_q   <= len_err_d;
      end
   end

endmodule

// File: tb/tb_vlc_pack_ctrl.sv
// Directed bench for vlc_pack_ctrl: packing, flush, back-pressure, len_err, clr and reset.
module tb_vlc_pack_ctrl;

   logic        clk = 1'b0;
   logic        rstN;
   logic        clr;
   logic [21:0] vlc_code;
   logic        vlc_valid;
   logic        vlc_ready;
   logic [31:0] out_word;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [2:0]  out_bytes;
   logic        len_err;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] wq[$];
   logic        lq[$];
   logic [2:0]  bq[$];

   vlc_pack_ctrl dut (
      .clk       (clk),
      .rstN      (rstN),
      .clr       (clr),
      .vlc_code  (vlc_code),
      .vlc_valid (vlc_valid),
      .vlc_ready (vlc_ready),
      .out_word  (out_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .out_bytes (out_bytes),
      .len_err   (len_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Record every word that will transfer at the coming rising edge
   always @(negedge clk) begin
      if (rstN && out_valid && out_ready) begin
         wq.push_back(out_word);
         lq.push_back(out_last);
         bq.push_back(out_bytes);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic last, input logic [4:0] len, input logic [15:0] code);
      int n = 0;
      vlc_code  = {last, len, code};
      vlc_valid = 1'b1;
      @(negedge clk);
      while (!vlc_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("send_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      vlc_valid = 1'b0;
   endtask

   task automatic clear_q();
      wq.delete();
      lq.delete();
      bq.delete();
   endtask

   // Expect exactly one collected word with the given fields
   task automatic expect_one(input string tag, input logic [31:0] w, input logic l, input logic [2:0] b);
      check({tag, "_count"}, 64'(wq.size()), 64'd1);
      if (wq.size() >= 1) begin
         check({tag, "_word"},  64'(wq[0]), 64'(w));
         check({tag, "_last"},  64'(lq[0]), 64'(l));
         check({tag, "_bytes"}, 64'(bq[0]), 64'(b));
      end
   endtask

   initial begin
      int acc;
      logic [3:0] nib [8];
      nib = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1, 4'h2};
      rstN = 1'b0; clr = 1'b0; vlc_code = '0; vlc_valid = 1'b0; out_ready = 1'b0;
      cycles(3);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_word",  64'(out_word),  64'd0);
      check("rst_out_last",  64'(out_last),  64'd0);
      check("rst_out_bytes", 64'(out_bytes), 64'd0);
      check("rst_len_err",   64'(len_err),   64'd0);
      check("rst_busy",      64'(busy),      64'd0);
      rstN = 1'b1;
      #1;
      check("rst_vlc_ready", 64'(vlc_ready), 64'd1);

      // Eight nibbles form one full word
      out_ready = 1'b1;
      clear_q();
      for (int i = 0; i < 8; i++) send(1'b0, 5'd4, 16'(nib[i]));
      cycles(4);
      expect_one("nib8", 32'hABCDEF12, 1'b0, 3'd4);
      check("nib8_busy", 64'(busy), 64'd0);

      // Short flush: 101 then 11 -> 0xB8000000, one byte
      clear_q();
      send(1'b0, 5'd3, 16'h5);
      send(1'b1, 5'd2, 16'h3);
      cycles(4);
      expect_one("short", 32'hB8000000, 1'b1, 3'd1);
      check("short_ready", 64'(vlc_ready), 64'd1);
      check("short_busy",  64'(busy),      64'd0);

      // Exactly full at flush: no trailing empty word
      clear_q();
      send(1'b0, 5'd16, 16'h1234);
      send(1'b1, 5'd16, 16'h5678);
      cycles(5);
      expect_one("full", 32'h12345678, 1'b1, 3'd4);

      // Back-pressure: six 16-bit codes fill the buffer and the output register
      clear_q();
      out_ready = 1'b0;
      acc = 0;
      vlc_code  = {1'b0, 5'd16, 16'hFFFF};
      vlc_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (vlc_ready) acc++;
      end
      check("bp_accepts",   64'(acc),       64'd6);
      check("bp_ready",     64'(vlc_ready), 64'd0);
      check("bp_valid",     64'(out_valid), 64'd1);
      check("bp_word",      64'(out_word),  64'hFFFFFFFF);
      @(posedge clk); #1;
      vlc_valid = 1'b0;
      cycles(3);
      check("bp_hold_word",  64'(out_word),  64'hFFFFFFFF);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("bp_drain_valid%0d", i), 64'(out_valid), (i < 3) ? 64'd1 : 64'd0);
      end
      check("bp_drain_count", 64'(wq.size()), 64'd3);
      foreach (wq[i]) check($sformatf("bp_drain_word%0d", i), 64'(wq[i]), 64'hFFFFFFFF);
      cycles(1);

      // Over-long code clamps to 16 bits; L=0 with last flushes it
      clear_q();
      send(1'b0, 5'd20, 16'hFFFF);
      check("ovf_len_err", 64'(len_err), 64'd1);
      send(1'b1, 5'd0, 16'h0);
      cycles(4);
      expect_one("ovf", 32'hFFFF0000, 1'b1, 3'd2);
      check("ovf_sticky", 64'(len_err), 64'd1);

      // clr drops buffered bits and len_err
      out_ready = 1'b0;
      send(1'b0, 5'd8, 16'hAB);
      check("clr_pre_busy", 64'(busy), 64'd1);
      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      check("clr_len_err",   64'(len_err),   64'd0);
      check("clr_busy",      64'(busy),      64'd0);
      check("clr_out_valid", 64'(out_valid), 64'd0);
      check("clr_ready",     64'(vlc_ready), 64'd1);

      // Empty flush yields a zero word with zero bytes
      out_ready = 1'b1;
      clear_q();
      send(1'b1, 5'd0, 16'h0);
      cycles(4);
      expect_one("empty", 32'h0, 1'b1, 3'd0);

      // Reset while stalled in FLUSH with a pending word
      out_ready = 1'b0;
      clear_q();
      send(1'b0, 5'd16, 16'h1111);
      send(1'b0, 5'd16, 16'h2222);
      send(1'b1, 5'd16, 16'h3333);
      cycles(2);
      check("rstf_pre_valid", 64'(out_valid), 64'd1);
      check("rstf_pre_busy",  64'(busy),      64'd1);
      #2;
      rstN = 1'b0;
      #1;
      check("rstf_valid", 64'(out_valid), 64'd0);
      check("rstf_busy",  64'(busy),      64'd0);
      cycles(1);
      rstN = 1'b1;
      #1;
      check("rstf_ready", 64'(vlc_ready), 64'd1);
      out_ready = 1'b1;
      clear_q();
      send(1'b1, 5'd4, 16'h9);
      cycles(4);
      expect_one("rstf_new", 32'h90000000, 1'b1, 3'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
